// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial register bridge and its
// helper blocks.
package serial_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_REG,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_SEND,
    ST_SEND_WAIT
  } state_e;

  localparam int unsigned RD_BIT     = 7;
  localparam int unsigned RSVD_HI    = 6;
  localparam int unsigned RSVD_LO    = 4;
  localparam int unsigned PERIPH_HI  = 3;
  localparam int unsigned PERIPH_LO  = 0;
  localparam int unsigned BUS_ADDR_W = 12;

  // A command byte is legal only when its reserved field is all zeros.
  function automatic logic cmd_rsvd_ok(input logic [7:0] cmd);
    return cmd[RSVD_HI:RSVD_LO] == 3'b000;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating idle-cycle counter; expired is raised on the TIMEOUT_CLKS-th
// consecutive enabled cycle after a clear.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CLKS = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of idle cycles already elapsed, so the
  // current enabled cycle is the last one allowed when it equals LAST.
  assign expired = enable && (count_q >= LAST);

endmodule

// File: rtl/serial_reg_bridge.sv
// UART packet parser: decodes 2/3-byte commands into register-bus strobes
// and returns read data through the UART transmitter.
module serial_reg_bridge
  import serial_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [11:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        err
);

  state_e state_q, state_d;
  logic   entry_q, entry_d;
  logic   is_rd_q, is_rd_d;

  logic                  rx_rd_q, rx_rd_d;
  logic                  tx_wr_q, tx_wr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [BUS_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]            bus_wdata_q, bus_wdata_d;
  logic                  bus_wr_q, bus_wr_d;
  logic                  bus_rd_q, bus_rd_d;
  logic                  err_q, err_d;

  logic rx_take;
  logic consume;
  logic to_clear;
  logic to_enable;
  logic to_expired;

  // The UART still shows the consumed byte while rx_rd is high.
  assign rx_take = rx_valid && !rx_rd_q;

  assign to_enable = (state_q == ST_GET_REG) || (state_q == ST_GET_DATA) ||
                     (state_q == ST_BUS_RD);
  assign to_clear  = (state_d != state_q) || consume;

  timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    rx_rd_d     = 1'b0;
    tx_wr_d     = 1'b0;
    bus_wr_d    = 1'b0;
    bus_rd_d    = 1'b0;
    err_d       = 1'b0;
    tx_data_d   = tx_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    consume     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_take) begin
          rx_rd_d = 1'b1;
          consume = 1'b1;
          if (!cmd_rsvd_ok(rx_data)) begin
            err_d = 1'b1;
          end else begin
            bus_addr_d[BUS_ADDR_W-1:8] = rx_data[PERIPH_HI:PERIPH_LO];
            is_rd_d                    = rx_data[RD_BIT];
            state_d                    = ST_GET_REG;
          end
        end
      end

      ST_GET_REG: begin
        if (rx_take) begin
          rx_rd_d         = 1'b1;
          consume         = 1'b1;
          bus_addr_d[7:0] = rx_data;
          state_d         = is_rd_q ? ST_BUS_RD : ST_GET_DATA;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_GET_DATA: begin
        if (rx_take) begin
          rx_rd_d     = 1'b1;
          consume     = 1'b1;
          bus_wdata_d = rx_data;
          state_d     = ST_BUS_WR;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_BUS_WR: begin
        bus_wr_d = 1'b1;
        state_d  = ST_IDLE;
      end

      // An ack in the same cycle as expiry still completes the read.
      ST_BUS_RD: begin
        bus_rd_d = entry_q;
        if (bus_ack) begin
          tx_data_d = bus_rdata;
          state_d   = ST_SEND;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_wr_d = 1'b1;
          state_d = ST_SEND_WAIT;
        end
      end

      // The first cycle here is skipped: tx_busy has not yet risen.
      ST_SEND_WAIT: begin
        if (!entry_q && !tx_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    entry_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      entry_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      rx_rd_q     <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      is_rd_q     <= is_rd_d;
      rx_rd_q     <= rx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wr_q    <= bus_wr_d;
      bus_rd_q    <= bus_rd_d;
      err_q       <= err_d;
    end
  end

  assign rx_rd     = rx_rd_q;
  assign tx_wr     = tx_wr_q;
  assign tx_data   = tx_data_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;
  assign err       = err_q;

endmodule
